// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Multi-cycle data-memory responder for the Memory stage, with
//               busy handshake for the hazard unit and sticky misalign flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemBusyM,
    output logic        ErrorM
);

    localparam int         c_IDX_W  = $clog2(DEPTH);
    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cntNext;
    logic                 w_commit;
    logic                 w_req;
    logic                 w_misaligned;
    logic [c_IDX_W-1:0]   w_idx;
    logic [31:0]          r_mem [DEPTH];
    logic [31:0]          r_readData;
    logic                 r_error;
    logic                 w_unused;

    assign w_req        = MemReadM | MemWriteM;
    assign w_misaligned = |AddrM[1:0];
    // Upper address bits are dropped so accesses alias modulo DEPTH words.
    assign w_idx        = AddrM[c_IDX_W+1:2];
    assign w_unused     = ^AddrM[31:c_IDX_W+2];

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_cntNext = c_LAT_M1;
                    if (LATENCY == 1) begin
                        w_stateNext = S_DONE;
                        w_commit    = 1'b1;
                    end else begin
                        w_stateNext = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_stateNext = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_stateNext = S_DONE;
                    w_commit    = 1'b1;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    assign MemBusyM = ((r_state == S_IDLE) && w_req) || (r_state == S_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_readData <= 32'd0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            if (w_commit) begin
                if (w_misaligned) begin
                    r_error    <= 1'b1;
                    r_readData <= 32'd0;
                end else if (MemReadM && !MemWriteM) begin
                    r_readData <= r_mem[w_idx];
                end
            end
        end
    end

    // Storage is never cleared; reset only has to block an in-flight commit.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && MemWriteM && !w_misaligned) begin
            r_mem[w_idx] <= WriteDataM;
        end
    end

    assign ReadDataM = r_readData;
    assign ErrorM    = r_error;

endmodule
`default_nettype wire
